// File: rtl/thirty_two_bit_one_two_demux_pkg.sv
// Shared constants for the 1:2 word demultiplexer and its per-output FIFOs.
// The optional push counters are enabled by the DEMUX_COUNT_EN macro.
package thirty_two_bit_one_two_demux_pkg;

    localparam int SIZE    = 32;
    localparam int DEPTH   = 2;
    localparam int COUNT_W = 16;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

endpackage

// File: rtl/thirty_two_bit_two_entry_fifo.sv
// Two-entry FIFO with 1-bit pointers; head reads as zero while empty.
// Push while full and pop while empty are ignored.
module thirty_two_bit_two_entry_fifo
    import thirty_two_bit_one_two_demux_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  logic [SIZE-1:0] data_in,
    input  logic            pop,
    output logic [SIZE-1:0] data_out,
    output logic [1:0]      count
);

    logic [SIZE-1:0] mem [DEPTH];
    logic            wr_ptr;
    logic            rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign do_push = push && (count != FULL_COUNT);
    assign do_pop  = pop && (count != 2'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; emptiness is tracked by count alone.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= data_in;
    end

    assign data_out = (count != 2'd0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/thirty_two_bit_one_two_demux.sv
// Registered 1:2 word demultiplexer with an independent 2-entry FIFO per output.
// Define DEMUX_COUNT_EN to add the 16-bit per-output push counters a_count/b_count.
module thirty_two_bit_one_two_demux
    import thirty_two_bit_one_two_demux_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [SIZE-1:0]    in_data,
    input  logic               in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [SIZE-1:0]    a_data,
    output logic               a_valid,
    input  logic               a_ready,
    output logic [SIZE-1:0]    b_data,
    output logic               b_valid,
    input  logic               b_ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [COUNT_W-1:0] a_count,
    output logic [COUNT_W-1:0] b_count
`endif
);

    logic [1:0] a_fill;
    logic [1:0] b_fill;
    logic       push_a;
    logic       push_b;
    logic       pop_a;
    logic       pop_b;

    // Ready comes only from registered fill levels, never from the consumers.
    assign in_ready = (in_sel == SEL_B) ? (b_fill != FULL_COUNT) : (a_fill != FULL_COUNT);

    assign push_a = in_valid && in_ready && (in_sel == SEL_A);
    assign push_b = in_valid && in_ready && (in_sel == SEL_B);
    assign pop_a  = a_valid && a_ready;
    assign pop_b  = b_valid && b_ready;

    assign a_valid = (a_fill != 2'd0);
    assign b_valid = (b_fill != 2'd0);

    thirty_two_bit_two_entry_fifo fifo_a (
        .clock    (clock),
        .reset    (reset),
        .push     (push_a),
        .data_in  (in_data),
        .pop      (pop_a),
        .data_out (a_data),
        .count    (a_fill)
    );

    thirty_two_bit_two_entry_fifo fifo_b (
        .clock    (clock),
        .reset    (reset),
        .push     (push_b),
        .data_in  (in_data),
        .pop      (pop_b),
        .data_out (b_data),
        .count    (b_fill)
    );

`ifdef DEMUX_COUNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (push_a) a_count <= a_count + 1'b1;
            if (push_b) b_count <= b_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_thirty_two_bit_one_two_demux.sv
// Self-checking bench: directed steps plus random traffic against a queue-based model.
// Counter checks are compiled in when DEMUX_COUNT_EN is defined.
module tb_thirty_two_bit_one_two_demux;

    logic        clock;
    logic        reset;
    logic [31:0] in_data;
    logic        in_sel;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_data;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] b_data;
    logic        b_valid;
    logic        b_ready;
`ifdef DEMUX_COUNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    thirty_two_bit_one_two_demux dut (
        .clock    (clock),
        .reset    (reset),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready)
`ifdef DEMUX_COUNT_EN
        ,
        .a_count  (a_count),
        .b_count  (b_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: one arrival-ordered queue per output, plus push tallies.
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int unsigned tally_a = 0;
    int unsigned tally_b = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic model_ready();
        return in_sel ? (qb.size() < 2) : (qa.size() < 2);
    endfunction

    task automatic compare_all();
        check("in_ready", {31'd0, in_ready}, {31'd0, model_ready()});
        check("a_valid", {31'd0, a_valid}, {31'd0, qa.size() != 0});
        check("b_valid", {31'd0, b_valid}, {31'd0, qb.size() != 0});
        check("a_data", a_data, (qa.size() != 0) ? qa[0] : 32'd0);
        check("b_data", b_data, (qb.size() != 0) ? qb[0] : 32'd0);
`ifdef DEMUX_COUNT_EN
        check("a_count", {16'd0, a_count}, tally_a & 32'hFFFF);
        check("b_count", {16'd0, b_count}, tally_b & 32'hFFFF);
`endif
    endtask

    // Apply inputs for the coming edge and compare outputs against the model.
    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic ra, input logic rb);
        in_valid = v;
        in_sel   = s;
        in_data  = d;
        a_ready  = ra;
        b_ready  = rb;
        #1;
        compare_all();
    endtask

    // Advance the model by the rules of one edge, then cross the edge.
    task automatic tick();
        logic acc;
        if (reset) begin
            qa.delete();
            qb.delete();
            tally_a = 0;
            tally_b = 0;
        end else begin
            acc = in_valid && model_ready();
            if (qa.size() != 0 && a_ready) void'(qa.pop_front());
            if (qb.size() != 0 && b_ready) void'(qb.pop_front());
            if (acc) begin
                if (in_sel) begin
                    qb.push_back(in_data);
                    tally_b++;
                end else begin
                    qa.push_back(in_data);
                    tally_a++;
                end
            end
        end
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic        hold;
        logic        s_r;
        logic [31:0] d_r;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = 32'd0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        @(posedge clock);
        #2;
        tick();
        reset = 1'b0;

        // Reset state
        drive(0, 0, 32'd0, 1, 1);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_a_valid", {31'd0, a_valid}, 32'd0);
        check("rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("rst_a_data", a_data, 32'h0);
        check("rst_b_data", b_data, 32'h0);
        tick();

        // One word to each output, consumers ready
        drive(1, 0, 32'h11111111, 1, 1);
        tick();
        drive(1, 1, 32'h22222222, 1, 1);
        check("first_a_data", a_data, 32'h11111111);
        check("first_a_valid", {31'd0, a_valid}, 32'd1);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        check("first_b_data", b_data, 32'h22222222);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        tick();

        // A stalled: fill it, B stays independent, then drain A in order
        drive(1, 0, 32'hA0, 0, 1);
        tick();
        drive(1, 0, 32'hA1, 0, 1);
        tick();
        drive(1, 0, 32'hA2, 0, 1);
        check("a_full_ready", {31'd0, in_ready}, 32'd0);
        tick();
        drive(1, 1, 32'hB0, 0, 1);
        check("b_open_ready", {31'd0, in_ready}, 32'd1);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        check("drain_a0", a_data, 32'hA0);
        check("b0_seen", b_data, 32'hB0);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        check("drain_a1", a_data, 32'hA1);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        check("a_empty", {31'd0, a_valid}, 32'd0);
        tick();

        // Simultaneous push and pop at count 1
        drive(1, 0, 32'hC0, 0, 1);
        tick();
        drive(1, 0, 32'hC1, 1, 1);
        check("pp_head_c0", a_data, 32'hC0);
        tick();
        drive(0, 0, 32'd0, 0, 1);
        check("pp_head_c1", a_data, 32'hC1);
        check("pp_valid", {31'd0, a_valid}, 32'd1);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        tick();
        drive(0, 0, 32'd0, 1, 1);
        check("pp_empty", {31'd0, a_valid}, 32'd0);
        tick();

        // Full push refused even with a pop in the same cycle
        drive(1, 1, 32'hD0, 1, 0);
        tick();
        drive(1, 1, 32'hD1, 1, 0);
        tick();
        drive(1, 1, 32'hD2, 1, 1);
        check("full_pop_ready", {31'd0, in_ready}, 32'd0);
        tick();
        drive(0, 1, 32'd0, 1, 1);
        check("full_pop_head", b_data, 32'hD1);
        tick();

        // B full, then reset drops everything
        drive(1, 1, 32'hD0, 1, 0);
        tick();
        drive(1, 1, 32'hD1, 1, 0);
        tick();
        reset = 1'b1;
        drive(1, 1, 32'hEE, 1, 1);
        tick();
        reset = 1'b0;
        drive(0, 1, 32'd0, 1, 0);
        check("post_rst_b_valid", {31'd0, b_valid}, 32'd0);
        check("post_rst_b_data", b_data, 32'h0);
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        tick();

        // Random traffic; a refused word is held until accepted
        hold = 1'b0;
        s_r  = 1'b0;
        d_r  = 32'd0;
        for (int i = 0; i < 600; i++) begin
            logic v;
            if (!hold) begin
                s_r = 1'($urandom);
                d_r = $urandom;
            end
            v = hold || ($urandom_range(0, 3) != 0);
            drive(v, s_r, d_r, ($urandom_range(0, 2) != 0), ($urandom_range(0, 3) == 0));
            hold = v && !in_ready;
            tick();
        end

`ifdef DEMUX_COUNT_EN
        reset = 1'b1;
        drive(0, 0, 32'd0, 1, 1);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            drive(1, 0, i, 1, 1);
            tick();
        end
        drive(0, 0, 32'd0, 1, 1);
        check("cnt_wrap_a", {16'd0, a_count}, 32'd1);
        check("cnt_wrap_b", {16'd0, b_count}, 32'd0);
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
